// File: rtl/jtag_shift_engine.sv
// rtl/jtag_shift_engine.sv - byte-command JTAG sequencer for the USB JTAG adapter
//
// Purpose: decodes a byte command stream into TCK/TMS/TDI shifts and
// TRST/SRST/output-enable control, and returns captured TDO or status bytes.
// Every output is driven straight from a CLK-domain flop.
//
// Ports:
//   CLK, RST_N                      system clock, async active-low reset
//   CMD_DATA/CMD_VALID/CMD_READY    command/data byte stream in
//   RSP_DATA/RSP_VALID/RSP_READY    response byte stream out
//   TCK_OUT/TMS_OUT/TDI_OUT         JTAG signals, JTAG_OE_N their enable
//   TRST_N_OUT/TRST_N_OE_N          TRST level and drive enable
//   SRST_N_OUT/SRST_N_OE_N          SRST level and drive enable
//   TDO_IN, SRST_N_IN               asynchronous target inputs
//   BUSY                            high whenever the engine is not idle
module jtag_shift_engine #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] CMD_DATA,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  output logic [7:0] RSP_DATA,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic       TCK_OUT,
  output logic       TMS_OUT,
  output logic       TDI_OUT,
  output logic       JTAG_OE_N,
  output logic       TRST_N_OUT,
  output logic       TRST_N_OE_N,
  output logic       SRST_N_OUT,
  output logic       SRST_N_OE_N,
  input  logic       TDO_IN,
  input  logic       SRST_N_IN,
  output logic       BUSY
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GETDATA = 3'd1;
  localparam logic [2:0] S_LO      = 3'd2;
  localparam logic [2:0] S_HI      = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       nlast_q, nlast_d;
  logic             tms_bit_q, tms_bit_d;
  logic             read_q, read_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic             jtag_oe_n_q, jtag_oe_n_d;
  logic             trst_n_q, trst_n_d, trst_oe_n_q, trst_oe_n_d;
  logic             srst_n_q, srst_n_d, srst_oe_n_q, srst_oe_n_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             tdo_meta_q, tdo_sync_q, srst_meta_q, srst_sync_q;

  logic             accept;
  logic [7:0]       cap_new;
  logic [2:0]       bit_nxt;

  // Bits 6:5 of a command byte carry no meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^CMD_DATA[6:5];

  assign accept = CMD_VALID && cmd_ready_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    nlast_d     = nlast_q;
    tms_bit_d   = tms_bit_q;
    read_d      = read_q;
    data_d      = data_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    jtag_oe_n_d = jtag_oe_n_q;
    trst_n_d    = trst_n_q;
    trst_oe_n_d = trst_oe_n_q;
    srst_n_d    = srst_n_q;
    srst_oe_n_d = srst_oe_n_q;
    cap_new     = cap_q;
    cap_new[bit_q] = tdo_sync_q;
    bit_nxt     = bit_q + 3'd1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (CMD_DATA[7]) begin
            nlast_d   = CMD_DATA[2:0];
            tms_bit_d = CMD_DATA[3];
            read_d    = CMD_DATA[4];
            state_d   = S_GETDATA;
          end else begin
            jtag_oe_n_d = ~CMD_DATA[0];
            trst_n_d    = ~CMD_DATA[1];
            trst_oe_n_d = ~CMD_DATA[1];
            srst_n_d    = ~CMD_DATA[2];
            srst_oe_n_d = ~CMD_DATA[2];
            if (CMD_DATA[3]) begin
              // Status reflects the control settings carried by this same byte.
              rsp_data_d  = {5'b0, CMD_DATA[1], CMD_DATA[0], srst_sync_q};
              rsp_valid_d = 1'b1;
              state_d     = S_RESP;
            end
          end
        end
      end
      S_GETDATA: begin
        if (accept) begin
          data_d  = CMD_DATA;
          cap_d   = 8'h00;
          bit_d   = 3'd0;
          div_d   = '0;
          tms_d   = tms_bit_q;
          tdi_d   = CMD_DATA[0];
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_HI;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_HI: begin
        if (div_q == DIV_LAST) begin
          // TDO is taken on the final CLK of the high phase, just before TCK falls.
          div_d = '0;
          cap_d = cap_new;
          if (bit_q == nlast_q) begin
            if (read_q) begin
              rsp_data_d  = cap_new;
              rsp_valid_d = 1'b1;
              state_d     = S_RESP;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d   = bit_nxt;
            tdi_d   = data_q[bit_nxt];
            state_d = S_LO;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Decoding from the next state keeps TCK, ready and busy as plain flops.
    tck_d       = (state_d == S_HI);
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_GETDATA);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= 3'd0;
      nlast_q     <= 3'd0;
      tms_bit_q   <= 1'b0;
      read_q      <= 1'b0;
      data_q      <= 8'h00;
      cap_q       <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      jtag_oe_n_q <= 1'b1;
      trst_n_q    <= 1'b1;
      trst_oe_n_q <= 1'b1;
      srst_n_q    <= 1'b1;
      srst_oe_n_q <= 1'b1;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      tdo_meta_q  <= 1'b1;
      tdo_sync_q  <= 1'b1;
      srst_meta_q <= 1'b1;
      srst_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      nlast_q     <= nlast_d;
      tms_bit_q   <= tms_bit_d;
      read_q      <= read_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      jtag_oe_n_q <= jtag_oe_n_d;
      trst_n_q    <= trst_n_d;
      trst_oe_n_q <= trst_oe_n_d;
      srst_n_q    <= srst_n_d;
      srst_oe_n_q <= srst_oe_n_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      tdo_meta_q  <= TDO_IN;
      tdo_sync_q  <= tdo_meta_q;
      srst_meta_q <= SRST_N_IN;
      srst_sync_q <= srst_meta_q;
    end
  end

  assign CMD_READY   = cmd_ready_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_VALID   = rsp_valid_q;
  assign TCK_OUT     = tck_q;
  assign TMS_OUT     = tms_q;
  assign TDI_OUT     = tdi_q;
  assign JTAG_OE_N   = jtag_oe_n_q;
  assign TRST_N_OUT  = trst_n_q;
  assign TRST_N_OE_N = trst_oe_n_q;
  assign SRST_N_OUT  = srst_n_q;
  assign SRST_N_OE_N = srst_oe_n_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb/tb_jtag_shift_engine.sv - scoreboard bench for jtag_shift_engine
module tb_jtag_shift_engine;

  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] CMD_DATA;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [7:0] RSP_DATA;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic       TCK_OUT, TMS_OUT, TDI_OUT, JTAG_OE_N;
  logic       TRST_N_OUT, TRST_N_OE_N, SRST_N_OUT, SRST_N_OE_N;
  logic       TDO_IN;
  logic       SRST_N_IN;
  logic       BUSY;

  logic tdo_loop = 1'b0;
  logic tdo_val  = 1'b1;
  assign TDO_IN = tdo_loop ? TDI_OUT : tdo_val;

  jtag_shift_engine #(.CLK_DIV(D), .DIV_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .TCK_OUT(TCK_OUT), .TMS_OUT(TMS_OUT), .TDI_OUT(TDI_OUT), .JTAG_OE_N(JTAG_OE_N),
    .TRST_N_OUT(TRST_N_OUT), .TRST_N_OE_N(TRST_N_OE_N),
    .SRST_N_OUT(SRST_N_OUT), .SRST_N_OE_N(SRST_N_OE_N),
    .TDO_IN(TDO_IN), .SRST_N_IN(SRST_N_IN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         rsp_cnt   = 0;
  int         tck_rises = 0;
  logic       tck_prev  = 1'b0;
  logic       tdi_log[0:255];
  logic       tms_log[0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe the DUT at the current negedge, then advance to the next negedge.
  task automatic tick();
    if (RSP_VALID && RSP_READY) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rsp_data", {24'd0, RSP_DATA}, {24'd0, exp_q.pop_front()});
      rsp_cnt++;
    end
    if (TCK_OUT && !tck_prev) begin
      tdi_log[tck_rises % 256] = TDI_OUT;
      tms_log[tck_rises % 256] = TMS_OUT;
      tck_rises++;
    end
    tck_prev = TCK_OUT;
    @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    CMD_DATA  = b;
    CMD_VALID = 1'b1;
    n = 0;
    while (!CMD_READY && n < 200) begin
      tick();
      n++;
    end
    if (!CMD_READY) check("cmd_ready_timeout", 32'd0, 32'd1);
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_shift(output int cnt);
    cnt = 0;
    while (BUSY && !RSP_VALID && cnt < 5000) begin
      cnt++;
      tick();
    end
  endtask

  function automatic logic [7:0] tdi_bits(input int base, input int n);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < n; i++) v[i] = tdi_log[(base + i) % 256];
    return v;
  endfunction

  function automatic logic [7:0] tms_bits(input int base, input int n);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < n; i++) v[i] = tms_log[(base + i) % 256];
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt, r0, n;
    CMD_DATA  = 8'h00;
    CMD_VALID = 1'b0;
    RSP_READY = 1'b1;
    SRST_N_IN = 1'b1;
    RST_N     = 1'b0;
    repeat (3) @(negedge CLK);

    check("rst_tck", TCK_OUT, 0);
    check("rst_tms", TMS_OUT, 1);
    check("rst_tdi", TDI_OUT, 0);
    check("rst_jtag_oe_n", JTAG_OE_N, 1);
    check("rst_trst", {TRST_N_OUT, TRST_N_OE_N}, 2'b11);
    check("rst_srst", {SRST_N_OUT, SRST_N_OE_N}, 2'b11);
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_data", RSP_DATA, 0);
    check("rst_cmd_ready", CMD_READY, 1);
    check("rst_busy", BUSY, 0);
    RST_N = 1'b1;
    tick();
    tick();

    // Control byte: enable JTAG, assert TRST and SRST.
    send_byte(8'h07);
    check("t1_jtag_oe_n", JTAG_OE_N, 0);
    check("t1_trst", {TRST_N_OUT, TRST_N_OE_N}, 2'b00);
    check("t1_srst", {SRST_N_OUT, SRST_N_OE_N}, 2'b00);
    check("t1_busy", BUSY, 0);
    check("t1_cmd_ready", CMD_READY, 1);

    // 8-bit read shift with TDO looped back; stall in GETDATA first.
    tdo_loop = 1'b1;
    base = tck_rises;
    send_byte(8'h97);
    repeat (5) tick();
    check("t2_getdata_tck", TCK_OUT, 0);
    check("t2_getdata_busy", BUSY, 1);
    check("t2_getdata_ready", CMD_READY, 1);
    check("t2_getdata_rises", tck_rises - base, 0);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    wait_shift(cnt);
    check("t2_cycles", cnt, 2 * 8 * D);
    tick();
    tick();
    check("t2_rises", tck_rises - base, 8);
    check("t2_tdi_bits", tdi_bits(base, 8), 8'hA5);
    check("t2_tms_bits", tms_bits(base, 8), 8'h00);
    check("t2_tck_idle", TCK_OUT, 0);
    check("t2_tdi_hold", TDI_OUT, 1);
    check("t2_busy_end", BUSY, 0);

    // 3-bit read shift with TMS=1 and TDO held high.
    tdo_loop = 1'b0;
    tdo_val  = 1'b1;
    base = tck_rises;
    exp_q.push_back(8'h07);
    send_byte(8'h9A);
    send_byte(8'h05);
    wait_shift(cnt);
    check("t3_cycles", cnt, 2 * 3 * D);
    tick();
    tick();
    check("t3_rises", tck_rises - base, 3);
    check("t3_tdi_bits", tdi_bits(base, 3), 8'h05);
    check("t3_tms_bits", tms_bits(base, 3), 8'h07);

    // 1-bit shift, no read.
    base = tck_rises;
    r0 = rsp_cnt;
    send_byte(8'h88);
    send_byte(8'h01);
    wait_shift(cnt);
    check("t4_cycles", cnt, 2 * 1 * D);
    check("t4_busy", BUSY, 0);
    check("t4_rsp_valid", RSP_VALID, 0);
    tick();
    tick();
    check("t4_rises", tck_rises - base, 1);
    check("t4_tms_bit", tms_bits(base, 1), 8'h01);
    check("t4_tms_hold", TMS_OUT, 1);
    check("t4_no_rsp", rsp_cnt - r0, 0);

    // Status read under response backpressure.
    SRST_N_IN = 1'b0;
    RSP_READY = 1'b0;
    repeat (3) tick();
    r0 = rsp_cnt;
    send_byte(8'h0B);
    for (int i = 0; i < 10; i++) begin
      check("t5_rsp_valid", RSP_VALID, 1);
      check("t5_rsp_data", RSP_DATA, 8'h06);
      check("t5_cmd_ready", CMD_READY, 0);
      tick();
    end
    check("t5_trst", {TRST_N_OUT, TRST_N_OE_N}, 2'b00);
    check("t5_srst", {SRST_N_OUT, SRST_N_OE_N}, 2'b11);
    check("t5_jtag_oe_n", JTAG_OE_N, 0);
    exp_q.push_back(8'h06);
    RSP_READY = 1'b1;
    tick();
    tick();
    check("t5_rsp_done", RSP_VALID, 0);
    check("t5_idle", {BUSY, CMD_READY}, 2'b01);
    check("t5_rsp_count", rsp_cnt - r0, 1);
    SRST_N_IN = 1'b1;

    // Reset during the 4th bit of an 8-bit read shift.
    base = tck_rises;
    send_byte(8'h97);
    send_byte(8'hFF);
    n = 0;
    while (tck_rises < base + 4 && n < 1000) begin
      tick();
      n++;
    end
    check("t6_reach_bit4", tck_rises - base, 4);
    tick();
    RST_N = 1'b0;
    #1;
    check("t6_tck", TCK_OUT, 0);
    check("t6_tms", TMS_OUT, 1);
    check("t6_oe_n", {JTAG_OE_N, TRST_N_OE_N, SRST_N_OE_N}, 3'b111);
    check("t6_busy", BUSY, 0);
    check("t6_rsp_valid", RSP_VALID, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    r0 = rsp_cnt;
    repeat (100) tick();
    check("t6_no_rsp", rsp_cnt - r0, 0);
    check("t6_no_more_tck", tck_rises - base, 4);
    check("t6_busy_after", BUSY, 0);

    check("rsp_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
